// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared definitions for the seq_divider block: default operand
//            width, FSM state encoding and the divide-by-zero quotient value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // FSM state encoding
  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_LOAD  = 2'd1;
  localparam logic [1:0] C_ST_ITER  = 2'd2;
  localparam logic [1:0] C_ST_FIXUP = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = C_ST_IDLE,
    LOAD  = C_ST_LOAD,
    ITER  = C_ST_ITER,
    FIXUP = C_ST_FIXUP
  } state_t;

  // Quotient reported for a zero divisor (all ones, i.e. -1)
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Purpose  : Handshake and operand/result bundle between the control unit
//            (master) and the sequential divider (slave).
// Signals  : start, dividend, divisor      master -> slave
//            busy, done, quotient,
//            remainder, div_zero           slave  -> master
// Revision : 1.0 - initial release
// ============================================================================
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational non-restoring division step. The partial
//            remainder is shifted left taking in the next dividend bit, then
//            the divisor is subtracted (P >= 0) or added (P < 0). The new
//            quotient bit is the inverted sign of the result.
// Ports    : i_p     WIDTH+1  partial remainder (signed)
//            i_d     WIDTH    divisor magnitude (unsigned)
//            i_bit   1        next dividend bit, MSB first
//            o_p     WIDTH+1  new partial remainder
//            o_q_bit 1        quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  wire logic [WIDTH:0]   i_p,
  input  wire logic [WIDTH-1:0] i_d,
  input  wire logic             i_bit,
  output logic      [WIDTH:0]   o_p,
  output logic                  o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_d_ext;

  assign w_shift = {i_p[WIDTH-1:0], i_bit};
  // Divisor magnitude can be 2^(WIDTH-1); the extra bit keeps it positive.
  assign w_d_ext = {1'b0, i_d};
  assign o_p     = i_p[WIDTH] ? (w_shift + w_d_ext) : (w_shift - w_d_ext);
  assign o_q_bit = ~o_p[WIDTH];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle signed divider (DIV: quotient -> LO, remainder ->
//            HI). Non-restoring radix-2 iteration on operand magnitudes,
//            followed by a remainder correction and sign fix-up. Results
//            truncate toward zero; the remainder carries the dividend sign.
// Ports    : clk   system clock, rising edge
//            clr   asynchronous active-high reset
//            bus   seq_divider_if.slave (start/operands in,
//                  busy/done/quotient/remainder/div_zero out)
// Macro    : DIV_ZERO_FAST_EN - a zero divisor skips the iteration phase so
//            done arrives two cycles after accept instead of WIDTH+2.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  wire logic    clk,
  input  wire logic    clr,
  seq_divider_if.slave bus
);

  localparam int             CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);
  // All-ones quotient, sized to WIDTH from the package constant
  localparam logic [WIDTH-1:0] C_ZQ     = {WIDTH{DIV_ZERO_QUOT[0]}};

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH:0]     r_p;        // partial remainder
  logic [WIDTH-1:0]   r_q;        // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]   r_d;        // divisor magnitude
  logic [WIDTH-1:0]   r_dvd_raw;  // original dividend, returned as remainder on /0
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_zero;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_step_p;
  logic               w_step_q;
  logic [WIDTH:0]     w_fix_p;
  logic [WIDTH-1:0]   w_mag_r;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  assign w_dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + C_ONE) : bus.dividend;
  assign w_dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + C_ONE)  : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p     (r_p),
    .i_d     (r_d),
    .i_bit   (r_q[WIDTH-1]),
    .o_p     (w_step_p),
    .o_q_bit (w_step_q)
  );

  // Final correction: a negative partial remainder still owes one divisor.
  assign w_fix_p = r_p[WIDTH] ? (r_p + {1'b0, r_d}) : r_p;
  assign w_mag_r = w_fix_p[WIDTH-1:0];
  assign w_quot  = r_sign_q ? (~r_q + C_ONE) : r_q;
  assign w_rem   = r_sign_r ? (~w_mag_r + C_ONE) : w_mag_r;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_p        <= '0;
      r_q        <= '0;
      r_d        <= '0;
      r_dvd_raw  <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_zero     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_q       <= w_dvd_mag;
            r_d       <= w_dvs_mag;
            r_dvd_raw <= bus.dividend;
            r_sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_sign_r  <= bus.dividend[WIDTH-1];
            r_zero    <= (bus.divisor == '0);
            r_busy    <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_p     <= '0;
          r_count <= '0;
`ifdef DIV_ZERO_FAST_EN
          r_state <= r_zero ? FIXUP : ITER;
`else
          r_state <= ITER;
`endif
        end
        ITER: begin
          r_p <= w_step_p;
          r_q <= {r_q[WIDTH-2:0], w_step_q};
          if (r_count == C_LAST) begin
            r_state <= FIXUP;
          end else begin
            r_count <= r_count + C_CNT_ONE;
          end
        end
        FIXUP: begin
          // A zero divisor overrides whatever the iteration produced.
          if (r_zero) begin
            r_quot <= C_ZQ;
            r_rem  <= r_dvd_raw;
          end else begin
            r_quot <= w_quot;
            r_rem  <= w_rem;
          end
          r_div_zero <= r_zero;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider. Results are compared
//            against a signed-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int W    = 32;
  localparam int LAT  = 34;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating signed division, remainder follows the dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one division starting #1 after an edge with the DUT idle; wait for
  // done, checking latency and results. inject_at >= 0 pulses a stray start
  // (9/3) at that many edges after accept.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input int inject_at, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int          lat;
    bit          seen;
    int          exp_lat;
    ref_div(a, b, eq, er);
    exp_lat = (b == 32'd0) ? ZLAT : LAT;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    check(64'(bus.busy), 64'd1, {tag, " busy"});
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      if (lat == inject_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    check(64'(seen), 64'd1, {tag, " done"});
    check(64'(lat), 64'(exp_lat), {tag, " latency"});
    check(64'(bus.quotient), 64'(eq), {tag, " quotient"});
    check(64'(bus.remainder), 64'(er), {tag, " remainder"});
    check(64'(bus.div_zero), 64'(b == 32'd0), {tag, " div_zero"});
    check(64'(bus.busy), 64'd0, {tag, " busy_end"});
  endtask

  initial begin : main
    logic [31:0] a;
    logic [31:0] b;
    bit          any_done;
    checks       = 0;
    errors       = 0;
    clr          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (2) @(posedge clk);
    #1;
    check(64'(bus.busy), 64'd0, "reset busy");
    check(64'(bus.done), 64'd0, "reset done");
    check(64'(bus.quotient), 64'd0, "reset quotient");
    check(64'(bus.remainder), 64'd0, "reset remainder");
    check(64'(bus.div_zero), 64'd0, "reset div_zero");
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;

    do_op(32'd100, 32'd7, -1, "100/7");
    @(posedge clk); #1;
    check(64'(bus.done), 64'd0, "done pulse width");
    check(64'(bus.quotient), 64'd14, "quotient hold");

    // Back-to-back: each following start lands in the previous done cycle
    do_op(32'hFFFF_FFF9, 32'd2, -1, "-7/2");
    do_op(32'd7, 32'hFFFF_FFFE, -1, "7/-2");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, -1, "min/-1");
    do_op(32'h8000_0000, 32'd1, -1, "min/1");
    do_op(32'd1234, 32'd0, -1, "1234/0");
    do_op(32'd50, 32'd5, 10, "50/5 stray start");
    check(64'(bus.quotient), 64'd10, "50/5 q literal");

    // Abort mid-operation
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    check(64'(bus.busy), 64'd0, "clr busy");
    check(64'(bus.done), 64'd0, "clr done");
    check(64'(bus.quotient), 64'd0, "clr quotient");
    check(64'(bus.remainder), 64'd0, "clr remainder");
    check(64'(bus.div_zero), 64'd0, "clr div_zero");
    @(negedge clk);
    clr = 1'b0;
    any_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      any_done |= bus.done;
    end
    check(64'(any_done), 64'd0, "clr no done");
    do_op(32'd9, 32'd4, -1, "9/4 after clr");

    // Randomized operands of several flavours
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      if (i % 3 == 0) a = 32'($urandom_range(0, 200));
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'd0 - 32'($urandom_range(1, 20));
        3:       b = 32'd0;
        default: b = 32'hFFFF_FFFF;
      endcase
      do_op(a, b, -1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
